y_diag_update_seq: RTL and testbench
====================================

// Module: y_diag_update_seq
// PURPOSE
//  Sequenced, parametrised successor to the single-shot Y-bus diagonal updater.
//  Takes one diagonal admittance element and applies up to MAX_TERMS branch changes to it: remove y_old, add y_new, or both.
//  Uses one shared registered complex add/sub path.
//  Sits between the branch-change scheduler and the Y-matrix store; valid/ready on all sides.
// PARAMETERS
//  WIDTH      48   packed complex word: [WIDTH-1:WIDTH/2]=real, [WIDTH/2-1:0]=imag, two's complement
//  MAX_TERMS  8    max branch terms per job
//  CNT_W      4    term counter width; must hold MAX_TERMS
// PORTS
//  clock        in   1      sole clock, rising edge
//  reset        in   1      asynchronous, active-low; clears all state
//  start_valid  in   1      job request
//  start_ready  out  1      high only in IDLE
//  y_diag_in    in   WIDTH  initial diagonal value
//  num_terms    in   CNT_W  terms in job; values >MAX_TERMS clamp to MAX_TERMS
//  term_valid   in   1      term available
//  term_ready   out  1      high only in ACC
//  term_mode    in   2      00 replace(-old,+new), 01 add new, 10 remove old, 11 skip
//  y_old        in   WIDTH  branch admittance removed
//  y_new        in   WIDTH  branch admittance added
//  res_valid    out  1      result held; high only in DONE
//  res_ready    in   1      consumer accepts result
//  y_diag_out   out  WIDTH  accumulated diagonal (the acc register)
//  ovf          out  1      sticky: any component overflow during job
//  busy         out  1      state != IDLE
// BEHAVIOUR
//  Reset (async, reset==0): state=IDLE; acc, latched new, count and ovf = 0; so res_valid=0 and y_diag_out=0.
//  Reset mid-job abandons the job; no partial result is emitted.
//  FSM states: IDLE, ACC, OP2, DONE.
//   IDLE, start accepted: acc<=y_diag_in; cnt<=clamp(num_terms); ovf<=0.
//    Next state is DONE if cnt==0, else ACC.
//   ACC, term accepted: cnt decrements.
//    Mode 01: acc+=y_new. Mode 10: acc-=y_old. Mode 11: acc unchanged.
//    Mode 00: acc-=y_old; y_new is latched; next state OP2.
//    Otherwise, next state is DONE if this was the last term, else ACC.
//   OP2: acc+=latched y_new; term_ready=0.
//    Next state is DONE if the count is exhausted, else ACC.
//   DONE: res_valid=1; y_diag_out stable.
//    res_valid && res_ready -> IDLE. A new start is accepted no earlier than the next cycle.
//  Arithmetic: real and imag are added/subtracted independently at WIDTH/2 bits each; no carry between halves.
//   Component overflow: both operands have the same sign and the result sign differs (sub: negate y_old first).
//   Overflow sets ovf; ovf holds until the next start.
//  Latency:
//   1 cycle per mode 01/10/11 term; 2 cycles per mode 00 term.
//   res_valid rises on the edge after the final op.
//   Zero-term job: res_valid on the edge after start accept, with y_diag_out = y_diag_in.
//  Backpressure: term_valid low in ACC stalls with no state change; res_ready low holds DONE indefinitely.
//  Inputs are sampled only on their handshake edge; y_old/y_new may change freely otherwise.
// CONFIGURATION
//  Y_SAT_EN defined: an overflowing component clamps to +2^(WIDTH/2-1)-1 or -2^(WIDTH/2-1); ovf is still set.
//  Y_SAT_EN undefined: components wrap modulo 2^(WIDTH/2); ovf is still set.
// TESTING  (WIDTH=48, MAX_TERMS=8; values shown as (re,im))
//  1. diag=(100,-50), 1 term mode00, old=(10,5), new=(30,-5):
//     -> y_diag_out=(120,-60), ovf=0, res_valid 3 edges after start accept.
//  2. diag=(0,0), 3 terms modes 01/10/11, new=(7,1), old=(2,3):
//     -> (5,-2); term_valid gaps stall correctly.
//  3. num_terms=0, diag=(9,9) -> res_valid next cycle, out=(9,9); num_terms=15 -> exactly 8 terms accepted.
//  4. diag=(8388607,0), mode01, new=(1,0):
//     -> ovf=1; out=(8388607,0) with Y_SAT_EN, (-8388608,0) without.
//  5. res_ready held low 5 cycles -> res_valid and out stable, start_ready=0; release -> IDLE, then next job accepted.
//  6. reset asserted during OP2 -> all outputs 0 immediately; state IDLE; a fresh job after release gives a correct result.

Source files
------------

// File: rtl/y_diag_update_seq.sv
// Sequenced Y-bus diagonal updater: applies up to MAX_TERMS branch changes to one diagonal element.
// Optional feature macro: Y_SAT_EN (saturate overflowing components instead of wrapping).
//
// state | meaning
// IDLE  | waiting for a job; acc holds the last result
// ACC   | accepting branch terms, one shared add/sub per cycle
// OP2   | second half of a replace term: add the latched y_new
// DONE  | result presented until the consumer takes it
module y_diag_update_seq #(
    parameter int WIDTH     = 48,
    parameter int MAX_TERMS = 8,
    parameter int CNT_W     = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] y_diag_in,
    input  logic [CNT_W-1:0] num_terms,
    input  logic             term_valid,
    output logic             term_ready,
    input  logic [1:0]       term_mode,
    input  logic [WIDTH-1:0] y_old,
    input  logic [WIDTH-1:0] y_new,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] y_diag_out,
    output logic             ovf,
    output logic             busy
);
    localparam int H = WIDTH / 2;

    typedef enum logic [1:0] {IDLE, ACC, OP2, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc, acc_nxt;
    logic [WIDTH-1:0] new_q, new_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] cnt_start;
    logic             ovf_q, ovf_nxt;
    logic [WIDTH-1:0] opnd;
    logic             op_sub;
    logic [H:0]       re_res, im_res;
    logic [WIDTH-1:0] op_res;
    logic             op_ovf;

    // Returns {overflow, result} for one component; halves never share a carry.
    function automatic logic [H:0] comp_op(input logic [H-1:0] a, input logic [H-1:0] b,
                                           input logic sub);
        logic [H-1:0] s;
        logic         o;
        s = sub ? a - b : a + b;
        if (sub)
            o = (a[H-1] != b[H-1]) && (s[H-1] != a[H-1]);
        else
            o = (a[H-1] == b[H-1]) && (s[H-1] != a[H-1]);
`ifdef Y_SAT_EN
        if (o)
            s = a[H-1] ? {1'b1, {(H-1){1'b0}}} : {1'b0, {(H-1){1'b1}}};
`endif
        return {o, s};
    endfunction

    assign cnt_start = (num_terms > CNT_W'(MAX_TERMS)) ? CNT_W'(MAX_TERMS) : num_terms;

    // Single shared add/sub path; operand chosen by state and term mode.
    always_comb begin
        opnd   = new_q;
        op_sub = 1'b0;
        if (state == ACC) begin
            if (term_mode == 2'b01) begin
                opnd = y_new;
            end else begin
                opnd   = y_old;
                op_sub = 1'b1;
            end
        end
        re_res = comp_op(acc[WIDTH-1:H], opnd[WIDTH-1:H], op_sub);
        im_res = comp_op(acc[H-1:0], opnd[H-1:0], op_sub);
        op_res = {re_res[H-1:0], im_res[H-1:0]};
        op_ovf = re_res[H] | im_res[H];
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        new_nxt   = new_q;
        cnt_nxt   = cnt;
        ovf_nxt   = ovf_q;
        case (state)
            IDLE: begin
                if (start_valid) begin
                    acc_nxt   = y_diag_in;
                    cnt_nxt   = cnt_start;
                    ovf_nxt   = 1'b0;
                    state_nxt = (cnt_start == '0) ? DONE : ACC;
                end
            end
            ACC: begin
                if (term_valid) begin
                    cnt_nxt = cnt - CNT_W'(1);
                    if (term_mode != 2'b11) begin
                        acc_nxt = op_res;
                        ovf_nxt = ovf_q | op_ovf;
                    end
                    if (term_mode == 2'b00) begin
                        new_nxt   = y_new;
                        state_nxt = OP2;
                    end else if (cnt == CNT_W'(1)) begin
                        state_nxt = DONE;
                    end
                end
            end
            OP2: begin
                acc_nxt   = op_res;
                ovf_nxt   = ovf_q | op_ovf;
                state_nxt = (cnt == '0) ? DONE : ACC;
            end
            DONE: begin
                if (res_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            acc   <= '0;
            new_q <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            new_q <= new_nxt;
            cnt   <= cnt_nxt;
            ovf_q <= ovf_nxt;
        end
    end

    assign start_ready = (state == IDLE);
    assign term_ready  = (state == ACC);
    assign res_valid   = (state == DONE);
    assign busy        = (state != IDLE);
    assign y_diag_out  = acc;
    assign ovf         = ovf_q;

endmodule

// File: tb/tb_y_diag_update_seq.sv
// Bench for y_diag_update_seq: directed cases plus randomized jobs against an integer-range reference model.
module tb_y_diag_update_seq;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [47:0] y_diag_in = '0;
    logic [3:0]  num_terms = '0;
    logic        term_valid = 1'b0;
    logic        term_ready;
    logic [1:0]  term_mode = '0;
    logic [47:0] y_old = '0;
    logic [47:0] y_new = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [47:0] y_diag_out;
    logic        ovf;
    logic        busy;

    int          total = 0;
    int          bad = 0;
    int          j_mode [16];
    logic [47:0] j_old  [16];
    logic [47:0] j_new  [16];

    always #5 clock = ~clock;

    y_diag_update_seq dut (
        .clock(clock), .reset(reset),
        .start_valid(start_valid), .start_ready(start_ready),
        .y_diag_in(y_diag_in), .num_terms(num_terms),
        .term_valid(term_valid), .term_ready(term_ready), .term_mode(term_mode),
        .y_old(y_old), .y_new(y_new),
        .res_valid(res_valid), .res_ready(res_ready),
        .y_diag_out(y_diag_out), .ovf(ovf), .busy(busy)
    );

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] pk(input int re, input int im);
        logic [23:0] r;
        logic [23:0] i;
        r = re[23:0];
        i = im[23:0];
        return {r, i};
    endfunction

    function automatic logic [47:0] rnd_val();
        logic [63:0] t;
        if ($urandom_range(0, 3) == 0) begin
            t = {$urandom, $urandom};
            return t[47:0];
        end
        return pk(int'($urandom_range(0, 2000)) - 1000, int'($urandom_range(0, 2000)) - 1000);
    endfunction

    // Reference: exact integer result per component, then range check decides overflow and wrap/clamp.
    function automatic logic [48:0] ref_op(input logic [47:0] a, input logic [47:0] b, input bit sub);
        logic [47:0] res;
        bit          o;
        logic [23:0] ac;
        logic [23:0] bc;
        longint      x;
        longint      y;
        longint      r;
        o = 1'b0;
        for (int c = 0; c < 2; c++) begin
            ac = a[c*24 +: 24];
            bc = b[c*24 +: 24];
            x  = longint'($signed(ac));
            y  = longint'($signed(bc));
            r  = sub ? x - y : x + y;
            if (r > 64'sd8388607 || r < -64'sd8388608) begin
                o = 1'b1;
`ifdef Y_SAT_EN
                r = (r > 0) ? 64'sd8388607 : -64'sd8388608;
`endif
            end
            res[c*24 +: 24] = r[23:0];
        end
        return {o, res};
    endfunction

    task automatic run_job(input logic [47:0] diag, input int num, input bit gaps, input int hold);
        logic [47:0] e;
        logic [48:0] t;
        bit          eo;
        int          n;
        int          k;
        n  = (num > 8) ? 8 : num;
        e  = diag;
        eo = 1'b0;
        chk("start_ready_idle", {47'b0, start_ready}, 48'd1);
        start_valid = 1'b1;
        y_diag_in   = diag;
        num_terms   = 4'(num);
        @(posedge clock);
        @(negedge clock);
        start_valid = 1'b0;
        y_diag_in   = rnd_val();
        num_terms   = 4'($urandom);
        if (n == 0)
            chk("zero_term_res_valid", {47'b0, res_valid}, 48'd1);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                k = $urandom_range(0, 2);
                repeat (k) begin
                    chk("stall_hold_acc", y_diag_out, e);
                    chk("stall_term_ready", {47'b0, term_ready}, 48'd1);
                    @(negedge clock);
                end
            end
            term_valid = 1'b1;
            term_mode  = 2'(j_mode[i]);
            y_old      = j_old[i];
            y_new      = j_new[i];
            k = 0;
            while (!term_ready && k < 20) begin
                @(negedge clock);
                k++;
            end
            chk("term_ready_wait", {47'b0, term_ready}, 48'd1);
            @(posedge clock);
            @(negedge clock);
            term_valid = 1'b0;
            y_old      = rnd_val();
            y_new      = rnd_val();
            term_mode  = 2'($urandom);
            case (j_mode[i])
                0: begin
                    t = ref_op(e, j_old[i], 1'b1); e = t[47:0]; eo |= t[48];
                    t = ref_op(e, j_new[i], 1'b0); e = t[47:0]; eo |= t[48];
                end
                1: begin t = ref_op(e, j_new[i], 1'b0); e = t[47:0]; eo |= t[48]; end
                2: begin t = ref_op(e, j_old[i], 1'b1); e = t[47:0]; eo |= t[48]; end
                default: ;
            endcase
            if (j_mode[i] == 0) begin
                chk("op2_term_ready", {47'b0, term_ready}, 48'd0);
                chk("op2_res_valid", {47'b0, res_valid}, 48'd0);
                @(negedge clock);
            end
            if (i == n - 1)
                chk("done_after_last", {47'b0, res_valid}, 48'd1);
            else
                chk("acc_after_term", {47'b0, term_ready}, 48'd1);
        end
        chk("result", y_diag_out, e);
        chk("ovf", {47'b0, ovf}, {47'b0, eo});
        repeat (hold) begin
            @(negedge clock);
            chk("hold_res_valid", {47'b0, res_valid}, 48'd1);
            chk("hold_out", y_diag_out, e);
            chk("hold_start_ready", {47'b0, start_ready}, 48'd0);
        end
        res_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        res_ready = 1'b0;
        chk("back_idle", {47'b0, start_ready}, 48'd1);
        chk("busy_clear", {47'b0, busy}, 48'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        chk("reset_out", y_diag_out, 48'd0);
        chk("reset_res_valid", {47'b0, res_valid}, 48'd0);
        chk("reset_ovf", {47'b0, ovf}, 48'd0);
        chk("reset_busy", {47'b0, busy}, 48'd0);
        chk("reset_start_ready", {47'b0, start_ready}, 48'd1);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        j_mode[0] = 0; j_old[0] = pk(10, 5); j_new[0] = pk(30, -5);
        run_job(pk(100, -50), 1, 1'b0, 0);
        chk("t1_const", y_diag_out, pk(120, -60));

        for (int i = 0; i < 3; i++) begin
            j_mode[i] = i + 1; j_old[i] = pk(2, 3); j_new[i] = pk(7, 1);
        end
        run_job(pk(0, 0), 3, 1'b1, 0);
        chk("t2_const", y_diag_out, pk(5, -2));

        run_job(pk(9, 9), 0, 1'b0, 0);
        chk("t3_zero_const", y_diag_out, pk(9, 9));
        for (int i = 0; i < 16; i++) begin
            j_mode[i] = $urandom_range(0, 3); j_old[i] = rnd_val(); j_new[i] = rnd_val();
        end
        run_job(rnd_val(), 15, 1'b1, 0);

        j_mode[0] = 1; j_new[0] = pk(1, 0); j_old[0] = rnd_val();
        run_job(pk(8388607, 0), 1, 1'b0, 0);
        chk("t4_ovf", {47'b0, ovf}, 48'd1);
`ifdef Y_SAT_EN
        chk("t4_out", y_diag_out, pk(8388607, 0));
`else
        chk("t4_out", y_diag_out, pk(-8388608, 0));
`endif
        j_mode[0] = 3;
        run_job(pk(1, 1), 1, 1'b0, 5);
        chk("t5_ovf_cleared", {47'b0, ovf}, 48'd0);

        start_valid = 1'b1; y_diag_in = pk(40, 40); num_terms = 4'd1;
        @(posedge clock);
        @(negedge clock);
        start_valid = 1'b0;
        term_valid = 1'b1; term_mode = 2'b00; y_old = pk(1, 1); y_new = pk(2, 2);
        @(posedge clock);
        @(negedge clock);
        term_valid = 1'b0;
        chk("t6_in_op2", {47'b0, term_ready}, 48'd0);
        reset = 1'b0;
        #1;
        chk("t6_rst_out", y_diag_out, 48'd0);
        chk("t6_rst_res_valid", {47'b0, res_valid}, 48'd0);
        chk("t6_rst_ovf", {47'b0, ovf}, 48'd0);
        chk("t6_rst_busy", {47'b0, busy}, 48'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("t6_no_partial", {47'b0, res_valid}, 48'd0);
        j_mode[0] = 0; j_old[0] = pk(3, -4); j_new[0] = pk(-6, 8);
        run_job(pk(50, 60), 1, 1'b0, 0);
        chk("t6_fresh", y_diag_out, pk(41, 72));

        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < 16; i++) begin
                j_mode[i] = $urandom_range(0, 3); j_old[i] = rnd_val(); j_new[i] = rnd_val();
            end
            run_job(rnd_val(), $urandom_range(0, 15), 1'($urandom), $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
